// File: rtl/pq_check_ctrl_if.sv
// rtl/pq_check_ctrl_if.sv - handshake bundle between the PQ checker and the priority queue
// Purpose: groups the priority-queue insert/remove strobes and status lines.
// Ports (master = checker side):
//   pq_full  PQ -> checker  PQ cannot accept an insert this cycle
//   pq_empty PQ -> checker  PQ holds no keys
//   pq_kvo   PQ -> checker  head (minimum) key
//   pq_enq   checker -> PQ  insert strobe, pq_kvi accepted when high
//   pq_deq   checker -> PQ  remove-head strobe
//   pq_kvi   checker -> PQ  key being inserted
interface pq_check_ctrl_if #(
  parameter int KW = 8
);
  logic          pq_full;
  logic          pq_empty;
  logic [KW-1:0] pq_kvo;
  logic          pq_enq;
  logic          pq_deq;
  logic [KW-1:0] pq_kvi;

  modport master (
    input  pq_full, pq_empty, pq_kvo,
    output pq_enq, pq_deq, pq_kvi
  );

  modport slave (
    output pq_full, pq_empty, pq_kvo,
    input  pq_enq, pq_deq, pq_kvi
  );
endinterface

// File: rtl/pq_check_ctrl.sv
// rtl/pq_check_ctrl.sv - fill/drain sequencer and self-checker for a min-first priority queue
// Purpose: on start, inserts NUM_KEYS keys in descending order, then drains the
//   queue and checks that heads come out as 0,1,2,... Reports pass, a saturating
//   error count and the first failing key.
// Optional feature: define STOP_ON_ERROR_EN to end the drain at the first mismatch.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      1-cycle pulse, accepted only in IDLE/DONE
//   pq         pq_check_ctrl_if.master (enq/deq/kvi out, full/empty/kvo in)
//   busy       high while a run is in progress
//   done       high once the run has finished, until the next start
//   pass       valid with done: no errors seen
//   err_count  mismatches + underruns, saturating at 255
//   fail_key   head key seen at the first mismatch, 0 if none
module pq_check_ctrl #(
  parameter int KW       = 8,
  parameter int NUM_KEYS = 16,
  parameter int SETTLE   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  pq_check_ctrl_if.master        pq,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [7:0]             err_count,
  output logic [KW-1:0]          fail_key
);

  // One extra bit so idx/count can represent NUM_KEYS == 2**KW.
  localparam int CW = KW + 1;
  localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE);

  typedef enum logic [2:0] {IDLE, FILL, FWAIT, CHK, DWAIT, DONE} state_t;

  state_t        state;
  logic [CW-1:0] idx;
  logic [CW-1:0] count;
  logic [SW-1:0] settle_cnt;
  logic          key_match;
  logic [7:0]    err_inc;

  assign key_match = (pq.pq_kvo == count[KW-1:0]);
  assign err_inc   = (err_count == 8'hFF) ? err_count : err_count + 8'd1;

  // Strobes follow the state; enq also yields to pq_full in the same cycle
  // so a stalled insert never leaks through.
  always_comb begin
    pq.pq_enq = (state == FILL) && !pq.pq_full;
    pq.pq_kvi = (state == FILL) ? (KW'(NUM_KEYS - 1) - idx[KW-1:0]) : '0;
`ifdef STOP_ON_ERROR_EN
    pq.pq_deq = (state == CHK) && !pq.pq_empty && key_match;
`else
    pq.pq_deq = (state == CHK) && !pq.pq_empty;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      count      <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_key   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= FILL;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_key   <= '0;
            idx        <= '0;
            count      <= '0;
            settle_cnt <= '0;
          end
        end

        FILL: begin
          if (!pq.pq_full) begin
            idx <= idx + 1'b1;
            if (idx == CW'(NUM_KEYS - 1)) begin
              state      <= FWAIT;
              count      <= '0;
              settle_cnt <= '0;
            end
          end
        end

        FWAIT, DWAIT: begin
          if (settle_cnt == SW'(SETTLE - 1)) begin
            settle_cnt <= '0;
            state      <= CHK;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        CHK: begin
          if (pq.pq_empty) begin
            // Underrun: queue ran dry before all keys were removed.
            err_count <= err_inc;
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= 1'b0;
          end else begin
            if (!key_match) begin
              err_count <= err_inc;
              if (err_count == 8'd0) fail_key <= pq.pq_kvo;
            end
`ifdef STOP_ON_ERROR_EN
            if (!key_match) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b0;
            end else
`endif
            begin
              count <= count + 1'b1;
              if (count == CW'(NUM_KEYS - 1)) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                // err_count updates this same edge, so fold in this check.
                pass  <= (err_count == 8'd0) && key_match;
              end else begin
                state <= DWAIT;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
